// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable clock dividers.
// Each channel counts 0..A_div and raises an event when it wraps. It produces
// either a 50% duty divided clock (toggle mode) or a one-cycle pulse (pulse
// mode), along with a tick strobe on every event. New configurations are
// written into a shadow register and applied only at an event boundary, or
// straight away if the channel is disabled.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   ch_en[NUM_CH]        per-channel run enable
//   cfg_we/cfg_ch        configuration write strobe and target channel
//   cfg_div/cfg_mode     divisor and mode (0 toggle, 1 pulse) to write
//   clk_out[NUM_CH]      registered divided output
//   tick[NUM_CH]         registered one-cycle event strobe
//   pending[NUM_CH]      shadow configuration not yet active
//   cfg_err              one-cycle strobe on a write to a nonexistent channel
module clk_div_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending,
  output logic              cfg_err
);

  localparam int unsigned ChIdxW = 5;

  // Rejected-write strobe; the compare is one bit wider so that NUM_CH = 16 fits.
  logic cfg_bad_c;
  logic cfg_err_q;

  assign cfg_bad_c = cfg_we && ({1'b0, cfg_ch} >= ChIdxW'(NUM_CH));

  always_ff @(posedge clk) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_bad_c;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Reset divisor 2^i - 1 gives clk/2, clk/4, clk/8, ... in toggle mode.
    localparam logic [CNT_W-1:0] RstDiv = CNT_W'((32'd1 << i) - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] a_div_q, a_div_d;
    logic [CNT_W-1:0] s_div_q, s_div_d;
    logic             a_mode_q, a_mode_d;
    logic             s_mode_q, s_mode_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_c;
    logic             evt_c;

    assign wr_c  = cfg_we && (cfg_ch == 4'(i));
    assign evt_c = (cnt_q == a_div_q);

    // Next-state logic for one channel.
    always_comb begin
      cnt_d    = cnt_q;
      a_div_d  = a_div_q;
      a_mode_d = a_mode_q;
      s_div_d  = s_div_q;
      s_mode_d = s_mode_q;
      pend_d   = pend_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;

      if (!ch_en[i]) begin
        cnt_d = '0;
        clk_d = 1'b0;
        // An idle channel adopts its shadow at once; a write landing in the
        // same cycle keeps pending set so that the newer value wins.
        if (pend_q && !wr_c) begin
          a_div_d  = s_div_q;
          a_mode_d = s_mode_q;
          pend_d   = 1'b0;
        end
      end else if (evt_c) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_q && !wr_c) begin
          a_div_d  = s_div_q;
          a_mode_d = s_mode_q;
          pend_d   = 1'b0;
        end
        // A mode switch starts the new mode from a clean low output.
        if (pend_q && !wr_c && (s_mode_q != a_mode_q)) clk_d = 1'b0;
        else if (a_mode_q)                              clk_d = 1'b1;
        else                                            clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (a_mode_q) clk_d = 1'b0;
      end

      // A write always lands in shadow, even when it coincides with an event.
      if (wr_c) begin
        s_div_d  = cfg_div;
        s_mode_d = cfg_mode;
        pend_d   = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        a_div_q  <= RstDiv;
        s_div_q  <= RstDiv;
        a_mode_q <= 1'b0;
        s_mode_q <= 1'b0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        a_div_q  <= a_div_d;
        s_div_q  <= s_div_d;
        a_mode_q <= a_mode_d;
        s_mode_q <= s_mode_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios followed by random traffic,
// checked every cycle against an event-timestamp reference model.
module tb_clk_div_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic           cfg_we;
  logic [3:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] clk_out, tick, pending;
  logic           cfg_err;

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .clk_out(clk_out), .tick(tick),
    .pending(pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: each running channel holds the absolute edge number of
  // its next event rather than a counter.
  int n = 0;
  int m_adiv[NCH], m_sdiv[NCH], m_next[NCH];
  bit m_amode[NCH], m_smode[NCH], m_pend[NCH], m_out[NCH], m_tick[NCH], m_run[NCH];
  bit m_err;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void model_step();
    n++;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_adiv[i] = (1 << i) - 1;  m_sdiv[i] = (1 << i) - 1;
        m_amode[i] = 0; m_smode[i] = 0; m_pend[i] = 0;
        m_out[i] = 0; m_tick[i] = 0; m_run[i] = 0;
      end
      m_err = 0;
      return;
    end
    m_err = cfg_we && (int'(cfg_ch) >= NCH);
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      wr = cfg_we && (int'(cfg_ch) == i);
      if (!ch_en[i]) begin
        m_run[i] = 0; m_out[i] = 0; m_tick[i] = 0;
        if (m_pend[i] && !wr) begin
          m_adiv[i] = m_sdiv[i]; m_amode[i] = m_smode[i]; m_pend[i] = 0;
        end
      end else begin
        if (!m_run[i]) begin
          m_run[i] = 1;
          m_next[i] = n + m_adiv[i];
        end
        if (n == m_next[i]) begin
          bit chg;
          chg = 0;
          if (m_pend[i] && !wr) begin
            chg = (m_smode[i] != m_amode[i]);
            m_adiv[i] = m_sdiv[i]; m_amode[i] = m_smode[i]; m_pend[i] = 0;
          end
          m_next[i] = n + m_adiv[i] + 1;
          m_tick[i] = 1;
          m_out[i] = chg ? 1'b0 : (m_amode[i] ? 1'b1 : !m_out[i]);
        end else begin
          m_tick[i] = 0;
          if (m_amode[i]) m_out[i] = 0;
        end
      end
      if (wr) begin
        m_sdiv[i] = int'(cfg_div); m_smode[i] = cfg_mode; m_pend[i] = 1;
      end
    end
  endfunction

  task automatic check();
    logic [NCH-1:0] e_out, e_tick, e_pend;
    for (int i = 0; i < NCH; i++) begin
      e_out[i] = m_out[i]; e_tick[i] = m_tick[i]; e_pend[i] = m_pend[i];
    end
    n_cmp++;
    assert (clk_out === e_out) else begin
      n_err++; $error("FAIL clk_out edge=%0d observed=%h expected=%h", n, clk_out, e_out);
    end
    n_cmp++;
    assert (tick === e_tick) else begin
      n_err++; $error("FAIL tick edge=%0d observed=%h expected=%h", n, tick, e_tick);
    end
    n_cmp++;
    assert (pending === e_pend) else begin
      n_err++; $error("FAIL pending edge=%0d observed=%h expected=%h", n, pending, e_pend);
    end
    n_cmp++;
    assert (cfg_err === m_err) else begin
      n_err++; $error("FAIL cfg_err edge=%0d observed=%b expected=%b", n, cfg_err, m_err);
    end
  endtask

  task automatic cyc(input int k = 1);
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      model_step();
      #1;
      check();
    end
  endtask

  task automatic wr(input int ch, input int dv, input bit md);
    cfg_we = 1; cfg_ch = 4'(ch); cfg_div = CW'(dv); cfg_mode = md;
    cyc();
    cfg_we = 0;
  endtask

  initial begin
    reset = 1; ch_en = '0; cfg_we = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
    for (int i = 0; i < NCH; i++) m_next[i] = 0;
    m_err = 0;
    #2;
    cyc(2);
    reset = 0;
    cyc(2);

    // Reset divisors: clk/2, /4, /8, /16 with all channels running.
    ch_en = '1;
    cyc(64);

    // Switch ch1 to pulse mode, D=4, partway through a period.
    cyc(1);
    wr(1, 4, 1);
    cyc(20);

    // Out-of-range channel index: only cfg_err reacts.
    wr(9, 3, 1);
    cyc(3);

    // ch0 to D=3, then rewrite it on the exact cycle of an event.
    wr(0, 3, 0);
    cyc(2);
    for (int k = 0; k < 10 && (m_next[0] != n + 1); k++) cyc();
    wr(0, 5, 0);
    cyc(16);

    // Disable ch2, reconfigure while idle, then re-enable.
    cyc(3);
    ch_en[2] = 0;
    cyc(3);
    wr(2, 2, 0);
    cyc(3);
    ch_en[2] = 1;
    cyc(10);

    // Reset while ch0 holds a pending write and is mid-count.
    wr(0, 9, 1);
    cyc(2);
    reset = 1; cfg_we = 1; cfg_ch = 4'd1; cfg_div = 8'd6;
    cyc();
    reset = 0; cfg_we = 0;
    cyc(24);

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 15) != 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(4, 15))
                                           : 4'($urandom_range(0, 3));
      cfg_div = CW'($urandom_range(0, 9));
      cfg_mode = 1'($urandom_range(0, 1));
      cyc();
    end
    reset = 0; cfg_we = 0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
